// File: rtl/router_out_port.sv
// Router output port: header-aware byte FIFO with registered data_out and end-of-packet blanking.
// Optional idle-destination timeout flush enabled by defining ROUTER_SOFT_RESET_EN.
module router_out_port #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             soft_reset
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = WIDTH - 1;

  if ((DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
    $error("router_out_port: DEPTH must be a power of two and TIMEOUT nonzero");
  end

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_pend_q, zero_pend_d;
  logic [WIDTH:0]   head;
  logic             flush;
  logic             rd_fire;
  logic             wr_fire;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_out = ~empty;
  assign data_out  = data_out_q;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_fire   = read_enb && !empty && !flush;
  assign wr_fire   = write_enb && !full && !flush;

  // Pointer advance, header-length tracking and post-parity blanking of data_out.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    cnt_d       = cnt_q;
    zero_pend_d = 1'b0;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_fire) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      data_out_d = head[WIDTH-1:0];
      if (head[WIDTH]) begin
        cnt_d = CW'(head[WIDTH-1:2]) + CW'(1);
      end else if (cnt_q != '0) begin
        cnt_d       = cnt_q - CW'(1);
        zero_pend_d = (cnt_q == CW'(1));
      end
    end else if (zero_pend_q) begin
      data_out_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_out_q  <= '0;
      cnt_q       <= '0;
      zero_pend_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_out_q  <= data_out_d;
      cnt_q       <= cnt_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  // Storage carries no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clock) begin
    if (wr_fire && !reset) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

`ifdef ROUTER_SOFT_RESET_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          soft_reset_q, soft_reset_d;

  // Counts consecutive cycles where data waits but the destination is not reading.
  always_comb begin
    timer_d      = '0;
    soft_reset_d = 1'b0;
    if (valid_out && !read_enb) begin
      if (timer_q == TW'(TIMEOUT - 1)) soft_reset_d = 1'b1;
      else timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || soft_reset_q) begin
      timer_q      <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign flush      = soft_reset_q;
  assign soft_reset = soft_reset_q;
`else
  assign flush      = 1'b0;
  assign soft_reset = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_port.sv
// Self-checking bench for router_out_port: queue-based reference model plus directed and random traffic.
module tb_router_out_port;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, full, empty, soft_reset;

  always #5 clock = ~clock;

  router_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .write_enb(write_enb), .lfd_state(lfd_state),
    .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .valid_out(valid_out), .full(full), .empty(empty), .soft_reset(soft_reset)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of stored entries plus packet/timeout bookkeeping.
  logic [8:0] m_q[$];
  logic [7:0] m_dout  = '0;
  int         m_cnt   = 0;
  bit         m_zp    = 1'b0;
  int         m_timer = 0;
  bit         m_srst  = 1'b0;
  bit         chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit we, input bit lfd, input logic [7:0] din,
                            input bit re, input bit rst);
    bit         was_empty;
    bit         was_full;
    bit         srst_next;
    logic [8:0] e;
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == DEPTH);
    srst_next = 1'b0;
    if (rst || m_srst) begin
      m_q.delete();
      m_dout = '0; m_cnt = 0; m_zp = 1'b0; m_timer = 0; m_srst = 1'b0;
      return;
    end
`ifdef ROUTER_SOFT_RESET_EN
    if (!was_empty && !re) begin
      m_timer++;
      if (m_timer == TIMEOUT) begin
        srst_next = 1'b1;
        m_timer   = 0;
      end
    end else begin
      m_timer = 0;
    end
`endif
    if (re && !was_empty) begin
      e = m_q.pop_front();
      m_dout = e[7:0];
      if (e[8]) begin
        m_cnt = int'(e[7:2]) + 1;
        m_zp  = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        m_zp = (m_cnt == 0);
      end else begin
        m_zp = 1'b0;
      end
    end else if (m_zp) begin
      m_dout = '0;
      m_zp   = 1'b0;
    end
    if (we && !was_full) m_q.push_back({lfd, din});
    m_srst = srst_next;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("data_out",   32'(data_out),   32'(m_dout));
      check("valid_out",  32'(valid_out),  32'(m_q.size() != 0));
      check("full",       32'(full),       32'(m_q.size() == DEPTH));
      check("empty",      32'(empty),      32'(m_q.size() == 0));
      check("soft_reset", 32'(soft_reset), 32'(m_srst));
    end
  end

  task automatic cycle(input bit we, input bit lfd, input logic [7:0] din,
                       input bit re, input bit rst);
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; reset = rst;
    @(posedge clock);
    model_step(we, lfd, din, re, rst);
    @(negedge clock);
  endtask

  task automatic wr(input bit lfd, input logic [7:0] d); cycle(1'b1, lfd, d, 1'b0, 1'b0); endtask
  task automatic rd();   cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic idle(); cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic rst();  cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); endtask

  initial begin
    reset = 1'b1; write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0; data_in = '0;
    @(negedge clock);
    rst();
    chk_en = 1'b1;
    rst();
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst empty", 32'(empty), 32'h1);
    check("rst full", 32'(full), 32'h0);
    check("rst valid", 32'(valid_out), 32'h0);
    check("rst soft_reset", 32'(soft_reset), 32'h0);

    // Header 0x0C: 3 payload bytes plus parity, then blank.
    wr(1'b1, 8'h0C); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33); wr(1'b0, 8'h44);
    rd(); check("pkt hdr", 32'(data_out), 32'h0C);
    rd(); check("pkt b1", 32'(data_out), 32'h11);
    rd(); check("pkt b2", 32'(data_out), 32'h22);
    rd(); check("pkt b3", 32'(data_out), 32'h33);
    rd(); check("pkt parity", 32'(data_out), 32'h44);
    idle(); check("pkt blank", 32'(data_out), 32'h00);

    // Fill, overflow drop, drain in order.
    rst();
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'hA0 + i));
    check("fill full", 32'(full), 32'h1);
    wr(1'b0, 8'hEE);
    check("overflow full", 32'(full), 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd(); check("drain order", 32'(data_out), 32'(8'hA0 + i));
    end
    check("drain empty", 32'(empty), 32'h1);

    // Full with simultaneous read and write: read proceeds, write dropped.
    rst();
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h50 + i));
    cycle(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    check("rw full data", 32'(data_out), 32'h50);
    check("rw full flag", 32'(full), 32'h0);
    for (int i = 0; i < 15; i++) rd();
    check("rw last byte", 32'(data_out), 32'h5F);
    check("rw empty", 32'(empty), 32'h1);

    // Reset mid-packet, then a fresh packet.
    rst();
    wr(1'b1, 8'h0C); wr(1'b0, 8'h21); wr(1'b0, 8'h22); wr(1'b0, 8'h23); wr(1'b0, 8'h24);
    rd(); rd();
    check("mid pkt", 32'(data_out), 32'h21);
    rst();
    check("mid rst data", 32'(data_out), 32'h00);
    check("mid rst empty", 32'(empty), 32'h1);
    wr(1'b1, 8'h08); wr(1'b0, 8'h31); wr(1'b0, 8'h32); wr(1'b0, 8'h33);
    rd(); check("new hdr", 32'(data_out), 32'h08);
    rd(); rd(); rd();
    idle(); check("new blank", 32'(data_out), 32'h00);

    // Pointer wrap with interleaved writes and reads.
    rst();
    for (int i = 0; i < 40; i++) begin
      wr(1'b0, 8'(i + 1));
      rd(); check("wrap order", 32'(data_out), 32'(i + 1));
    end

    // Idle destination.
    rst();
    wr(1'b0, 8'h77);
    for (int c = 1; c < 30; c++) idle();
    check("timeout pre", 32'(soft_reset), 32'h0);
    idle();
`ifdef ROUTER_SOFT_RESET_EN
    check("timeout pulse", 32'(soft_reset), 32'h1);
    idle();
    check("timeout flushed", 32'(empty), 32'h1);
    check("timeout pulse end", 32'(soft_reset), 32'h0);
`else
    check("no timeout", 32'(soft_reset), 32'h0);
    idle();
    check("no timeout hold", 32'(valid_out), 32'h1);
`endif
    rst();
    wr(1'b0, 8'h61); wr(1'b0, 8'h62);
    for (int c = 0; c < 27; c++) idle();
    rd(); idle();
    check("read before timeout", 32'(soft_reset), 32'h0);

    // Randomized traffic in phases of differing read pressure.
    rst();
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 800; n++) begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 8'($urandom),
              $urandom_range(0, 5) < ph * 2, $urandom_range(0, 599) == 0);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
